vc_wr_chnl_sched: RTL and testbench

Write-channel scheduler for the vector cache data array. Arbitrates write/linefill commands leaving the WEST/EAST/SOUTH/NORTH write arbiters and the linefill path onto the CHANNEL shared SRAM write channels. Each source reaches its channel a fixed number of cycles after grant (WR_CMD_DELAY_*) and then holds it for DS_N beats. The scheduler keeps a per-channel reservation timeline so that no two granted commands ever occupy a channel in the same cycle.

---
 rtl/vc_wr_chnl_sched.sv | 132 +++++++++++++
 tb/tb_vc_wr_chnl_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_wr_chnl_sched.sv
// Write-channel scheduler: round-robin grant of source commands onto shared SRAM
// write channels, guarded by a per-channel reservation timeline.
module vc_wr_chnl_sched #(
  parameter int SRC_NUM = 5,
  parameter int CHANNEL = 8,
  parameter int OCC_CYC = 4,
  parameter int DLY_W   = 2,
  parameter int DLY_E   = 3,
  parameter int DLY_S   = 6,
  parameter int DLY_N   = 4,
  parameter int DLY_LF  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SRC_NUM-1:0]     req_vld_i,
  input  logic [SRC_NUM*3-1:0]   req_chnl_i,
  output logic [SRC_NUM-1:0]     req_rdy_o,
  output logic                   gnt_vld_o,
  output logic [2:0]             gnt_src_o,
  output logic [2:0]             gnt_chnl_o,
  output logic [CHANNEL-1:0]     chnl_busy_o,
  output logic [CHANNEL-1:0]     chnl_start_o,
  output logic [CHANNEL*3-1:0]   chnl_start_src_o
);

  localparam int DLY_MAX_WE  = (DLY_W > DLY_E) ? DLY_W : DLY_E;
  localparam int DLY_MAX_SN  = (DLY_S > DLY_N) ? DLY_S : DLY_N;
  localparam int DLY_MAX_4   = (DLY_MAX_WE > DLY_MAX_SN) ? DLY_MAX_WE : DLY_MAX_SN;
  localparam int DLY_MAX     = (DLY_MAX_4 > DLY_LF) ? DLY_MAX_4 : DLY_LF;
  localparam int TL_W        = DLY_MAX + OCC_CYC;
  localparam logic [TL_W-1:0] OCC_ONES = TL_W'((1 << OCC_CYC) - 1);

  function automatic int src_dly(input int s);
    case (s)
      0:       return DLY_W;
      1:       return DLY_E;
      2:       return DLY_S;
      3:       return DLY_N;
      default: return DLY_LF;
    endcase
  endfunction

  logic [TL_W-1:0]    tl_q   [CHANNEL];
  logic [TL_W-1:0]    tl_d   [CHANNEL];
  logic [TL_W-1:0]    st_q   [CHANNEL];
  logic [TL_W-1:0]    st_d   [CHANNEL];
  logic [2:0]         sid_q  [CHANNEL][TL_W];
  logic [2:0]         sid_d  [CHANNEL][TL_W];
  logic [2:0]         rr_ptr_q;
  logic [2:0]         rr_ptr_d;
  logic [2:0]         src_chnl [SRC_NUM];
  logic [SRC_NUM-1:0] elig;
  logic               gnt_vld;
  logic [2:0]         gnt_src;
  logic [2:0]         gnt_chnl;
  int                 gnt_dly;
  int                 rr_idx;

  // A source is eligible only when its whole future occupancy window is free.
  for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_src
    localparam int D = src_dly(gi);
    assign src_chnl[gi]  = req_chnl_i[gi*3 +: 3];
    assign elig[gi]      = rst_n && req_vld_i[gi] &&
                           (tl_q[src_chnl[gi]][D+OCC_CYC-1 -: OCC_CYC] == '0);
    assign req_rdy_o[gi] = gnt_vld && (gnt_src == 3'(gi));
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_src  = '0;
    gnt_chnl = '0;
    rr_idx   = 0;
    for (int k = 0; k < SRC_NUM; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % SRC_NUM;
      if (!gnt_vld && elig[rr_idx]) begin
        gnt_vld  = 1'b1;
        gnt_src  = 3'(rr_idx);
        gnt_chnl = src_chnl[rr_idx];
      end
    end
  end

  assign gnt_dly = src_dly(int'(gnt_src));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld)
      rr_ptr_d = (gnt_src == 3'(SRC_NUM-1)) ? 3'd0 : gnt_src + 3'd1;
    for (int c = 0; c < CHANNEL; c++) begin
      tl_d[c] = tl_q[c] >> 1;
      st_d[c] = st_q[c] >> 1;
      for (int k = 0; k < TL_W-1; k++)
        sid_d[c][k] = sid_q[c][k+1];
      sid_d[c][TL_W-1] = '0;
      // Reservation lands one bit lower than the eligibility window: it is
      // written into the already-shifted timeline.
      if (gnt_vld && (gnt_chnl == 3'(c))) begin
        tl_d[c]            = tl_d[c] | (OCC_ONES << (gnt_dly - 1));
        st_d[c][gnt_dly-1]  = 1'b1;
        sid_d[c][gnt_dly-1] = gnt_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      for (int c = 0; c < CHANNEL; c++) begin
        tl_q[c] <= '0;
        st_q[c] <= '0;
        for (int k = 0; k < TL_W; k++)
          sid_q[c][k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tl_q     <= tl_d;
      st_q     <= st_d;
      sid_q    <= sid_d;
    end
  end

  for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_chnl
    assign chnl_busy_o[gi]            = tl_q[gi][0];
    assign chnl_start_o[gi]           = st_q[gi][0];
    assign chnl_start_src_o[gi*3 +: 3] = sid_q[gi][0];
  end

  assign gnt_vld_o  = gnt_vld;
  assign gnt_src_o  = gnt_src;
  assign gnt_chnl_o = gnt_chnl;

endmodule

// File: tb/tb_vc_wr_chnl_sched.sv
// Scoreboard bench for vc_wr_chnl_sched: a reservation-map reference model
// predicts each cycle's grant and channel outputs; a monitor pops and compares.
module tb_vc_wr_chnl_sched;

  localparam int SRC_NUM = 5;
  localparam int CHANNEL = 8;
  localparam int OCC     = 4;
  localparam int NCYC    = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_vld = '0;
  logic [14:0] req_chnl = '0;
  logic [4:0]  req_rdy;
  logic        gnt_vld;
  logic [2:0]  gnt_src;
  logic [2:0]  gnt_chnl;
  logic [7:0]  chnl_busy;
  logic [7:0]  chnl_start;
  logic [23:0] chnl_start_src;

  always #5 clk = ~clk;

  vc_wr_chnl_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_vld_i        (req_vld),
    .req_chnl_i       (req_chnl),
    .req_rdy_o        (req_rdy),
    .gnt_vld_o        (gnt_vld),
    .gnt_src_o        (gnt_src),
    .gnt_chnl_o       (gnt_chnl),
    .chnl_busy_o      (chnl_busy),
    .chnl_start_o     (chnl_start),
    .chnl_start_src_o (chnl_start_src)
  );

  typedef struct packed {
    logic [4:0]  rdy;
    logic        gv;
    logic [2:0]  gs;
    logic [2:0]  gc;
    logic [7:0]  busy;
    logic [7:0]  start;
    logic [23:0] ssrc;
  } exp_t;

  typedef struct {
    int c;
    int s;
    int ch;
  } ev_t;

  // Reference model: absolute-cycle ownership map per channel.
  int   res_src [CHANNEL][NCYC];
  bit   res_st  [CHANNEL][NCYC];
  int   cyc = 0;
  int   rr = 0;
  int   last_gnt = -1;
  bit   pend    [SRC_NUM];
  int   pend_ch [SRC_NUM];
  exp_t exp_q[$];
  ev_t  scen_q[$];
  exp_t mon_e;
  int   mon_cyc = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic int dly_of(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      2:       return 6;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, mon_cyc, act, req);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (last_gnt >= 0) pend[last_gnt] = 1'b0;
    last_gnt = -1;
  endtask

  task automatic finish_cycle(input bit in_rst);
    exp_t e;
    int   g;
    bit   free;
    if (cyc + 16 >= NCYC) begin
      $display("FAIL model_capacity cyc=%0d actual=%0d required<%0d", cyc, cyc + 16, NCYC);
      $fatal(1, "model capacity exceeded");
    end
    for (int s = 0; s < SRC_NUM; s++) begin
      req_vld[s]         = pend[s];
      req_chnl[s*3 +: 3] = 3'(pend_ch[s]);
    end
    e = '0;
    if (in_rst) begin
      rst_n = 1'b0;
      for (int c = 0; c < CHANNEL; c++)
        for (int u = cyc; u < NCYC; u++) begin
          res_src[c][u] = -1;
          res_st[c][u]  = 1'b0;
        end
      rr = 0;
      for (int s = 0; s < SRC_NUM; s++) pend[s] = 1'b0;
    end else begin
      rst_n = 1'b1;
      g = -1;
      for (int k = 0; k < SRC_NUM; k++) begin
        int s;
        s = (rr + k) % SRC_NUM;
        if (g < 0 && pend[s]) begin
          free = 1'b1;
          for (int i = 0; i < OCC; i++)
            if (res_src[pend_ch[s]][cyc + dly_of(s) + i] != -1) free = 1'b0;
          if (free) g = s;
        end
      end
      if (g >= 0) begin
        for (int i = 0; i < OCC; i++)
          res_src[pend_ch[g]][cyc + dly_of(g) + i] = g;
        res_st[pend_ch[g]][cyc + dly_of(g)] = 1'b1;
        rr       = (g + 1) % SRC_NUM;
        last_gnt = g;
        e.gv     = 1'b1;
        e.gs     = 3'(g);
        e.gc     = 3'(pend_ch[g]);
        e.rdy[g] = 1'b1;
      end
      for (int c = 0; c < CHANNEL; c++) begin
        if (res_src[c][cyc] != -1) e.busy[c] = 1'b1;
        if (res_st[c][cyc]) begin
          e.start[c]       = 1'b1;
          e.ssrc[c*3 +: 3] = 3'(res_src[c][cyc]);
        end
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic add_ev(input int c, input int s, input int ch);
    ev_t ev;
    ev.c = c; ev.s = s; ev.ch = ch;
    scen_q.push_back(ev);
  endtask

  task automatic run_scen(input int n, input int rst_at);
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      finish_cycle(1'b1);
    end
    for (int rel = 0; rel < n; rel++) begin
      begin_cycle();
      foreach (scen_q[j])
        if (scen_q[j].c == rel) begin
          pend[scen_q[j].s]    = 1'b1;
          pend_ch[scen_q[j].s] = scen_q[j].ch;
        end
      finish_cycle(rel == rst_at);
    end
    scen_q.delete();
  endtask

  task automatic run_rand(input int n, input int pct, input int cmax, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      for (int s = 0; s < SRC_NUM; s++)
        if (!pend[s] && int'($urandom_range(99)) < pct) begin
          pend[s]    = 1'b1;
          pend_ch[s] = int'($urandom_range(cmax));
        end
      finish_cycle(int'($urandom_range(99)) < rst_pct);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("req_rdy", 32'(req_rdy), 32'(mon_e.rdy));
      chk("grant", 32'(gnt_vld ? {1'b1, gnt_src, gnt_chnl} : 7'd0),
                   32'(mon_e.gv ? {1'b1, mon_e.gs, mon_e.gc} : 7'd0));
      chk("chnl_busy", 32'(chnl_busy), 32'(mon_e.busy));
      chk("chnl_start", 32'(chnl_start), 32'(mon_e.start));
      chk("chnl_start_src", 32'(chnl_start_src), 32'(mon_e.ssrc));
      mon_cyc++;
    end
  end

  initial begin
    for (int c = 0; c < CHANNEL; c++)
      for (int u = 0; u < NCYC; u++) begin
        res_src[c][u] = -1;
        res_st[c][u]  = 1'b0;
      end
    for (int s = 0; s < SRC_NUM; s++) begin
      pend[s]    = 1'b0;
      pend_ch[s] = 0;
    end

    // Conflict on ch3: W then E, back-to-back reservations.
    add_ev(0, 0, 3); add_ev(1, 1, 3);
    run_scen(16, -1);
    // Gap fill on ch1 in front of a linefill reservation.
    add_ev(0, 4, 1); add_ev(1, 0, 1); add_ev(2, 2, 1);
    run_scen(20, -1);
    // Round-robin across all sources; W re-requests right after its grant.
    for (int s = 0; s < SRC_NUM; s++) add_ev(0, s, s);
    add_ev(1, 0, 5);
    run_scen(16, -1);
    // Same cycle, same channel: N and LF on ch7.
    add_ev(0, 3, 7); add_ev(0, 4, 7);
    run_scen(16, -1);
    // Reset mid-operation drops W's reservation and rewinds the pointer.
    add_ev(0, 0, 0); add_ev(4, 1, 2); add_ev(4, 0, 2);
    run_scen(16, 1);

    run_rand(600, 30, 7, 0);
    run_rand(600, 70, 1, 0);
    run_rand(600, 90, 0, 0);
    run_rand(500, 50, 3, 2);

    begin_cycle();
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
